// File: rtl/mul32_seq_pkg.sv
// mul32_seq_pkg: shared constants and the FSM state type for the iterative
// multiplier. WIDTH is the operand width (product is 2*WIDTH). CNT_W is the
// iteration counter width and must hold WIDTH. Only WIDTH=32 is usable while
// the accumulate step goes through cla_32.
package mul32_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul32_seq_if.sv
// mul32_seq_if: operand/product handshake bundle for mul32_seq.
//   in_valid/in_ready  : operand handshake (a, b, op_signed qualified by in_valid)
//   out_valid/out_ready: product handshake (product held while out_valid)
//   busy               : multiplier is iterating or applying the sign fix
// master = requester (drives operands, consumes product)
// slave  = the multiplier
interface mul32_seq_if;
  import mul32_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_signed;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    product;
  logic             busy;

  modport master (
    output in_valid, a, b, op_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, op_signed, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/cla_32.sv
// cla_32: 32-bit two-level carry-lookahead adder.
//   a, b : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out
// Eight 4-bit lookahead groups; group generate/propagate feed a second-level
// carry computation. Every in-group carry is expressed directly in terms of
// the group carry-in so no carry bit depends on another bit of its own vector.
module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [7:0] grp_g;
  logic [7:0] grp_p;
  logic [8:0] gc;

  always_comb begin
    gc[0] = cin;
    for (int i = 0; i < 8; i++) begin
      gc[i+1] = grp_g[i] | (grp_p[i] & gc[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grp
      localparam int B = gi * 4;
      logic [3:0] gg;
      logic [3:0] pp;
      logic [3:0] cc;

      assign gg = a[B+:4] & b[B+:4];
      assign pp = a[B+:4] ^ b[B+:4];

      assign cc[0] = gc[gi];
      assign cc[1] = gg[0] | (pp[0] & gc[gi]);
      assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[gi]);
      assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                   | (pp[2] & pp[1] & pp[0] & gc[gi]);

      assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                       | (pp[3] & pp[2] & pp[1] & gg[0]);
      assign grp_p[gi] = &pp;

      assign s[B+:4] = pp ^ cc;
    end
  endgenerate

  assign cout = gc[8];

endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: iterative radix-2 shift-and-add multiplier, signed or unsigned.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any in-flight operation)
//   bus  : mul32_seq_if.slave -- in_valid/in_ready, a, b, op_signed,
//          out_valid/out_ready, product (2*WIDTH), busy
// Flow: IDLE accepts operands and stores their magnitudes; CALC does one
// conditional add-and-shift per clock for WIDTH clocks; FIX applies the
// result sign once; DONE holds the product until out_ready.
// Accept in cycle 0 -> busy in cycles 1..WIDTH+1 -> out_valid in cycle WIDTH+2.
module mul32_seq
  import mul32_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mul32_seq_if.slave bus
);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] mag_a_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_reg;
  logic [PW-1:0]    product_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic [WIDTH-1:0] mag_a_next;
  logic [WIDTH-1:0] mag_b_next;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    product_next;

  // Magnitudes: a negative signed operand is stored two's-complemented.
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  assign mag_a_next = (bus.op_signed && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign mag_b_next = (bus.op_signed && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

  // Multiplier bit currently in acc_lo[0] selects whether |a| is added.
  assign addend = acc_lo_reg[0] ? mag_a_reg : '0;

  cla_32 u_add (
    .a    (acc_hi_reg),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  // Right shift of the whole accumulator, with the adder carry entering the top.
  assign acc_next = {carry, sum, acc_lo_reg[WIDTH-1:1]};

  assign product_next = neg_reg ? (~{acc_hi_reg, acc_lo_reg} + PW'(1))
                                : {acc_hi_reg, acc_lo_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      acc_hi_reg    <= '0;
      acc_lo_reg    <= '0;
      mag_a_reg     <= '0;
      cnt_reg       <= '0;
      neg_reg       <= 1'b0;
      product_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            mag_a_reg    <= mag_a_next;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= mag_b_next;
            cnt_reg      <= '0;
            neg_reg      <= bus.op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            state_reg    <= S_CALC;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        S_CALC: begin
          {acc_hi_reg, acc_lo_reg} <= acc_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          product_reg   <= product_next;
          state_reg     <= S_DONE;
          busy_reg      <= 1'b0;
          out_valid_reg <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.product   = product_reg;

endmodule
